// File: rtl/instr_loader_pkg.sv
// Shared types and byte codes for the UART instruction loader.
// Holds the frame FSM state encoding and the sync/ack/nak byte values.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    COUNT = 3'd2,
    DATA  = 3'd3,
    CSUM  = 3'd4
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/loader_idle_timer.sv
// Inter-byte idle counter: clears on every byte, counts only while enabled.
// expire is a combinational one-cycle pulse when TIMEOUT_CYCLES-1 idle clocks have elapsed.
module loader_idle_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // A byte in the same cycle always wins over expiry.
  assign expire = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !en) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/instr_uart_loader.sv
// UART frame loader (SYNC, ADDR, COUNT, 4*N data bytes MSB first, CSUM) into instruction memory; write one cycle after each 4th byte.
// Never stalls byte intake; LOADER_ECHO_EN adds an ACK/NAK reply port held until tx_ready.
module instr_uart_loader
  import instr_loader_pkg::*;
#(
  parameter int INSTR_WIDTH    = 32,
  parameter int INSTR_DEPTH    = 256,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                           clk,
  input  logic                           fsm_rst_n,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic                           wr_en,
  output logic [$clog2(INSTR_DEPTH)-1:0] wr_addr,
  output logic [INSTR_WIDTH-1:0]         wr_data,
  output logic                           fsm_hold,
  output logic                           done,
  output logic                           err,
  output logic [8:0]                     words_loaded
`ifdef LOADER_ECHO_EN
  ,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready
`endif
);

  localparam int AW = $clog2(INSTR_DEPTH);

  loader_state_t          state;
  logic [AW-1:0]          addr;
  logic [AW-1:0]          next_addr;
  logic [8:0]             count;
  logic [1:0]             byte_idx;
  logic [INSTR_WIDTH-1:0] shift;
  logic [INSTR_WIDTH-1:0] next_word;
  logic [7:0]             sum;
  logic                   expire;

  assign next_word = {shift[INSTR_WIDTH-9:0], rx_data};
  assign next_addr = (addr == AW'(INSTR_DEPTH - 1)) ? '0 : addr + AW'(1);

  loader_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (fsm_rst_n),
    .clr   (rx_valid),
    .en    (state != IDLE),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (!fsm_rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      count        <= '0;
      byte_idx     <= '0;
      shift        <= '0;
      sum          <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      fsm_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (expire) begin
        // Partial word is simply abandoned; nothing is written.
        state    <= IDLE;
        err      <= 1'b1;
        fsm_hold <= 1'b0;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state    <= ADDR;
              err      <= 1'b0;
              fsm_hold <= 1'b1;
            end
          end
          ADDR: begin
            addr  <= AW'(rx_data);
            sum   <= rx_data;
            state <= COUNT;
          end
          COUNT: begin
            count        <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            sum          <= sum + rx_data;
            words_loaded <= '0;
            byte_idx     <= '0;
            state        <= DATA;
          end
          DATA: begin
            shift    <= next_word;
            sum      <= sum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wr_en        <= 1'b1;
              wr_data      <= next_word;
              wr_addr      <= addr;
              addr         <= next_addr;
              words_loaded <= words_loaded + 9'd1;
              if (words_loaded + 9'd1 == count) begin
                state <= CSUM;
              end
            end
          end
          CSUM: begin
            if (rx_data == sum) begin
              done <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state    <= IDLE;
            fsm_hold <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            fsm_hold <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LOADER_ECHO_EN
  logic frame_end;
  logic frame_ok;

  assign frame_end = expire || (rx_valid && state == CSUM);
  assign frame_ok  = rx_valid && state == CSUM && rx_data == sum;

  // A reply still waiting on tx_ready keeps its byte; a newer one is dropped.
  always_ff @(posedge clk) begin
    if (!fsm_rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (frame_end && (!tx_valid || tx_ready)) begin
        tx_valid <= 1'b1;
        tx_data  <= frame_ok ? ACK_BYTE : NAK_BYTE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_uart_loader.sv
// Scoreboard bench for instr_uart_loader: expected writes queued as frames are driven, popped on wr_en.
module tb_instr_uart_loader;
  import instr_loader_pkg::*;

  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        fsm_rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        fsm_hold;
  logic        done;
  logic        err;
  logic [8:0]  words_loaded;
`ifdef LOADER_ECHO_EN
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
`endif

  always #5 clk = ~clk;

  instr_uart_loader #(
    .INSTR_WIDTH   (32),
    .INSTR_DEPTH   (256),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .fsm_rst_n   (fsm_rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .fsm_hold    (fsm_hold),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
`ifdef LOADER_ECHO_EN
    ,
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int d0;

  logic [39:0] exp_q[$];
  logic [31:0] frame_words[$];

  task automatic check_val(input string tag, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_wr", {39'd0, wr_en}, 40'd0);
      end else begin
        check_val("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] cnt_byte, input bit bad);
    logic [7:0]  s;
    logic [31:0] w;
    int n;
    n = frame_words.size();
    s = a + cnt_byte;
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      exp_q.push_back({a + 8'(i), w});
      s = s + w[31:24] + w[23:16] + w[15:8] + w[7:0];
    end
    send_byte(SYNC_BYTE);
    check_val("hold_after_sync", {39'd0, fsm_hold}, 40'd1);
    send_byte(a);
    send_byte(cnt_byte);
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
    end
    check_val("hold_before_csum", {39'd0, fsm_hold}, 40'd1);
    send_byte(bad ? 8'h00 : s);
    check_val("done", {39'd0, done}, {39'd0, !bad});
    check_val("err", {39'd0, err}, {39'd0, bad});
    check_val("hold_end", {39'd0, fsm_hold}, 40'd0);
    check_val("words_loaded", {31'd0, words_loaded}, 40'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_wr_en"}, {39'd0, wr_en}, 40'd0);
    check_val({tag, "_wr_addr"}, {32'd0, wr_addr}, 40'd0);
    check_val({tag, "_wr_data"}, {8'd0, wr_data}, 40'd0);
    check_val({tag, "_hold"}, {39'd0, fsm_hold}, 40'd0);
    check_val({tag, "_done"}, {39'd0, done}, 40'd0);
    check_val({tag, "_err"}, {39'd0, err}, 40'd0);
    check_val({tag, "_words"}, {31'd0, words_loaded}, 40'd0);
  endtask

  initial begin
    fsm_rst_n = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
`ifdef LOADER_ECHO_EN
    tx_ready  = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    fsm_rst_n = 1'b1;
    idle(2);

    // Good two-word frame, CSUM 0xC5
    frame_words = '{32'h80000001, 32'h40000002};
    d0 = done_cnt;
    send_frame(8'h00, 8'h02, 1'b0);
`ifdef LOADER_ECHO_EN
    check_val("tx_ack_valid", {39'd0, tx_valid}, 40'd1);
    check_val("tx_ack_data", {32'd0, tx_data}, {32'd0, ACK_BYTE});
`endif
    idle(2);
    check_val("good_done_once", 40'(done_cnt - d0), 40'd1);
    check_val("good_sb_empty", 40'(exp_q.size()), 40'd0);

    // Address wrap 255 -> 0
    frame_words = '{32'h00100000, 32'h00100000};
    d0 = done_cnt;
    send_frame(8'hFF, 8'h02, 1'b0);
    idle(2);
    check_val("wrap_done_once", 40'(done_cnt - d0), 40'd1);
    check_val("wrap_sb_empty", 40'(exp_q.size()), 40'd0);

    // Bad checksum: words still written, err set
`ifdef LOADER_ECHO_EN
    tx_ready = 1'b0;
`endif
    frame_words = '{32'h80000001, 32'h40000002};
    d0 = done_cnt;
    send_frame(8'h00, 8'h02, 1'b1);
    idle(3);
    check_val("bad_no_done", 40'(done_cnt - d0), 40'd0);
    check_val("bad_err_sticky", {39'd0, err}, 40'd1);
    check_val("bad_sb_empty", 40'(exp_q.size()), 40'd0);
`ifdef LOADER_ECHO_EN
    check_val("tx_nak_valid", {39'd0, tx_valid}, 40'd1);
    check_val("tx_nak_data", {32'd0, tx_data}, {32'd0, NAK_BYTE});
    tx_ready = 1'b1;
    @(negedge clk);
    check_val("tx_nak_taken", {39'd0, tx_valid}, 40'd0);
`endif

    // Timeout with a partial word
    send_byte(SYNC_BYTE);
    check_val("to_err_cleared", {39'd0, err}, 40'd0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(TO - 1);
    check_val("to_not_yet_err", {39'd0, err}, 40'd0);
    check_val("to_not_yet_hold", {39'd0, fsm_hold}, 40'd1);
    idle(1);
    check_val("to_err", {39'd0, err}, 40'd1);
    check_val("to_hold_low", {39'd0, fsm_hold}, 40'd0);
    idle(5);
    check_val("to_no_write", 40'(exp_q.size()), 40'd0);
    frame_words = '{32'hDEADBEEF};
    send_frame(8'h03, 8'h01, 1'b0);
    idle(2);

    // Reset in the middle of a frame
    send_byte(SYNC_BYTE);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    fsm_rst_n = 1'b0;
    rx_valid  = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    fsm_rst_n = 1'b1;
    idle(3);
    check_val("midrst_no_write", 40'(exp_q.size()), 40'd0);

    // 0xA5 inside the frame is data
    frame_words = '{32'hA5A5A5A5};
    send_frame(8'h05, 8'h01, 1'b0);
    idle(2);
    check_val("a5_sb_empty", 40'(exp_q.size()), 40'd0);

    // Back-to-back COUNT=0 frame: 256 words
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back((32'(i) * 32'h01020304) ^ 32'hA5000000);
    d0 = done_cnt;
    send_frame(8'h10, 8'h00, 1'b0);
    idle(2);
    check_val("b2b_done_once", 40'(done_cnt - d0), 40'd1);
    check_val("b2b_words", {31'd0, words_loaded}, 40'd256);
    check_val("b2b_sb_empty", 40'(exp_q.size()), 40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
